wb128_inst_responder: RTL and testbench
=======================================

Name: wb128_inst_responder

Overview:
- Wishbone B3 slave with a 128-bit data bus and 32-bit address.
- Stands in for system memory in front of the Amber-class core under test.
- Serves instruction words supplied by a stimulus source on lane 0, with a fixed filler word in the upper three lanes.
- Acknowledges and captures core write cycles for a monitor.
- Generates the core's static side-band inputs: irq, firq and system_rdy.

Parameters:
- FILL_WORD, 32'hF0081003, word driven on lanes 1-3 of every read, and on all lanes when no instruction is held.
- RDY_DELAY, 10, i_clk cycles after reset release before o_system_rdy asserts (range 1-255).

Ports:
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_inst  in  32  instruction word from the stimulus source.
- i_inst_valid  in  1  i_inst is valid this cycle.
- o_inst_ready  out  1  holding register is empty and can accept i_inst.
- i_wb_adr  in  32  Wishbone address from the core.
- i_wb_sel  in  16  byte selects.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_dat  in  128  write data from the core.
- o_wb_dat  out  128  read data to the core.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_ack  out  1  acknowledge.
- o_wb_err  out  1  error terminate.
- o_wr_valid  out  1  one-cycle pulse: write captured.
- o_wr_adr  out  32  captured write address.
- o_wr_sel  out  16  captured write selects.
- o_wr_dat  out  128  captured write data.
- o_irq  out  1  interrupt request to the core.
- o_firq  out  1  fast interrupt request to the core.
- o_system_rdy  out  1  system-ready to the core.

Behaviour:
Reset values: while i_rst=1 every output is 0, except o_inst_ready=1 and o_wb_dat = {4{FILL_WORD}}.

Holding register (1 entry) and handshake:
- Loads i_inst on a rising edge when i_inst_valid && o_inst_ready.
- Becomes empty on the edge where a read is acknowledged.
- Load and consume in the same cycle cannot occur, because ready is 0 while the register is full.
- o_inst_ready equals NOT full; it is registered.

Transaction request and termination:
- A request is i_wb_cyc && i_wb_stb && !o_wb_ack && !o_wb_err.
- A request is terminated exactly one cycle later by a single-cycle pulse of o_wb_ack or o_wb_err.
- The pulse never lasts two cycles, even if stb stays high. A held stb is treated as a new request in the cycle after the pulse drops.

Read (i_wb_we=0):
- With the ack, o_wb_dat = {FILL_WORD, FILL_WORD, FILL_WORD, held_inst}.
- If the register is empty, o_wb_dat = {4{FILL_WORD}} and the read is still acked. No wait states are inserted.
- o_wb_dat holds its last value between transactions.

Write (i_wb_we=1):
- With the ack, o_wr_valid pulses for one cycle.
- o_wr_adr, o_wr_sel and o_wr_dat latch i_wb_adr, i_wb_sel and i_wb_dat as sampled in the request cycle, and hold until the next write.
- The holding register is not affected.

Error: a request with i_wb_sel == 0 is terminated with o_wb_err instead of ack. No data is consumed and no write is captured.

Abort: if i_wb_cyc drops in the cycle a termination is pending, the pulse still fires and the state change (consume or capture) still occurs.

Side-band outputs:
- o_irq and o_firq are registered constant 0.
- o_system_rdy asserts after a counter reaches RDY_DELAY cycles following reset deassertion, then stays 1 until the next reset.
- Requests before o_system_rdy=1 are served normally.

Reset mid-transaction:
- Asynchronously clears any pending ack/err and the holding register.
- Clears the ready counter.
- o_wr_* return to 0.

Decomposition:
- Shared package wb128_pkg holds FILL_WORD_DEFAULT, the WB_DW=128 and WB_AW=32 constants, and a wb_req_t struct (adr, sel, we, dat).
- One sub-module is natural: rdy_delay_counter, which produces o_system_rdy.
- Everything else stays in the top module.

Test Plan:
- Reset, then release; count edges -> o_system_rdy rises on edge 10, with o_irq=o_firq=0 throughout.
- Load i_inst=32'hE3A01005, then one read with sel=16'hFFFF -> the ack the next cycle carries o_wb_dat=96'hF0081003F0081003F0081003 concatenated with E3A01005; o_inst_ready returns to 1.
- Read with no instruction held -> ack, and o_wb_dat = 128'hF0081003F0081003F0081003F0081003.
- Write adr=32'h100, sel=16'h000F, dat=128'h1234 -> one-cycle ack, and o_wr_valid=1 with the captured fields equal to those values.
- Read with sel=0 -> o_wb_err pulses one cycle, o_wb_ack stays 0, and the holding register remains full.
- stb held high for 4 cycles with reads, plus i_rst pulsed while an ack is pending -> ack alternates 1,0,1,0; the reset clears ack immediately and restarts the RDY_DELAY count.

Source files
------------

// File: rtl/wb128_pkg.sv
// Shared constants, request bundle and termination-state type for the 128-bit
// Wishbone instruction responder.
package wb128_pkg;

   localparam int unsigned WB_DW = 128;
   localparam int unsigned WB_AW = 32;
   localparam int unsigned WB_SW = WB_DW / 8;

   localparam logic [31:0] FILL_WORD_DEFAULT = 32'hF0081003;

   typedef struct packed {
      logic [WB_AW-1:0] adr;
      logic [WB_SW-1:0] sel;
      logic             we;
      logic [WB_DW-1:0] dat;
   } wb_req_t;

   typedef enum logic [1:0] {
      TermIdle,
      TermAck,
      TermErr
   } term_state_e;

   // Read beat: the instruction sits in lane 0, filler occupies lanes 1-3.
   function automatic logic [WB_DW-1:0] read_beat(input logic [31:0] fill,
                                                   input logic [31:0] lane0);
      return {fill, fill, fill, lane0};
   endfunction

endpackage

// File: rtl/rdy_delay_counter.sv
// Raises system_rdy on the RDY_DELAY-th clock edge after reset release and
// holds it until the next reset.
module rdy_delay_counter
   import wb128_pkg::*;
#(
   parameter int unsigned RDY_DELAY = 10
) (
   input  logic clk,
   input  logic rst,
   output logic system_rdy
);

   localparam logic [7:0] LAST_COUNT = 8'(RDY_DELAY - 1);

   logic [7:0] count_q, count_d;
   logic       rdy_q, rdy_d;

   always_comb begin
      count_d = count_q;
      rdy_d   = rdy_q;
      if (!rdy_q) begin
         count_d = count_q + 8'd1;
         if (count_q == LAST_COUNT) begin
            rdy_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 8'd0;
         rdy_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         rdy_q   <= rdy_d;
      end
   end

   assign system_rdy = rdy_q;

endmodule

// File: rtl/wb128_inst_responder.sv
// Wishbone B3 slave standing in for system memory: serves one held instruction
// per read, captures writes for a monitor and drives the core's side-band inputs.
module wb128_inst_responder
   import wb128_pkg::*;
#(
   parameter logic [31:0] FILL_WORD = FILL_WORD_DEFAULT,
   parameter int unsigned RDY_DELAY = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_inst,
   input  logic             i_inst_valid,
   output logic             o_inst_ready,
   input  logic [WB_AW-1:0] i_wb_adr,
   input  logic [WB_SW-1:0] i_wb_sel,
   input  logic             i_wb_we,
   input  logic [WB_DW-1:0] i_wb_dat,
   output logic [WB_DW-1:0] o_wb_dat,
   input  logic             i_wb_cyc,
   input  logic             i_wb_stb,
   output logic             o_wb_ack,
   output logic             o_wb_err,
   output logic             o_wr_valid,
   output logic [WB_AW-1:0] o_wr_adr,
   output logic [WB_SW-1:0] o_wr_sel,
   output logic [WB_DW-1:0] o_wr_dat,
   output logic             o_irq,
   output logic             o_firq,
   output logic             o_system_rdy
);

   wb_req_t bus;

   term_state_e      state_q, state_d;
   logic             inst_ready_q, inst_ready_d;
   logic [31:0]      inst_q, inst_d;
   logic [WB_DW-1:0] rd_dat_q, rd_dat_d;
   logic             wr_valid_q, wr_valid_d;
   logic [WB_AW-1:0] wr_adr_q, wr_adr_d;
   logic [WB_SW-1:0] wr_sel_q, wr_sel_d;
   logic [WB_DW-1:0] wr_dat_q, wr_dat_d;
   logic             irq_q, firq_q;

   logic full;
   logic req;
   logic inst_load;

   assign bus = '{adr: i_wb_adr, sel: i_wb_sel, we: i_wb_we, dat: i_wb_dat};

   assign full      = ~inst_ready_q;
   // A termination in flight masks the bus, so a held stb re-requests only after it drops.
   assign req       = i_wb_cyc & i_wb_stb & (state_q == TermIdle);
   assign inst_load = i_inst_valid & inst_ready_q;

   always_comb begin
      state_d      = TermIdle;
      inst_ready_d = inst_ready_q;
      inst_d       = inst_q;
      rd_dat_d     = rd_dat_q;
      wr_valid_d   = 1'b0;
      wr_adr_d     = wr_adr_q;
      wr_sel_d     = wr_sel_q;
      wr_dat_d     = wr_dat_q;

      if (inst_load) begin
         inst_d       = i_inst;
         inst_ready_d = 1'b0;
      end

      if (req) begin
         if (bus.sel == '0) begin
            state_d = TermErr;
         end else begin
            state_d = TermAck;
            if (bus.we) begin
               wr_valid_d = 1'b1;
               wr_adr_d   = bus.adr;
               wr_sel_d   = bus.sel;
               wr_dat_d   = bus.dat;
            end else begin
               rd_dat_d = read_beat(FILL_WORD, full ? inst_q : FILL_WORD);
               // Consume only when full; a load can only happen when empty.
               if (full) begin
                  inst_ready_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= TermIdle;
         inst_ready_q <= 1'b1;
         inst_q       <= 32'd0;
         rd_dat_q     <= {4{FILL_WORD}};
         wr_valid_q   <= 1'b0;
         wr_adr_q     <= '0;
         wr_sel_q     <= '0;
         wr_dat_q     <= '0;
         irq_q        <= 1'b0;
         firq_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         inst_ready_q <= inst_ready_d;
         inst_q       <= inst_d;
         rd_dat_q     <= rd_dat_d;
         wr_valid_q   <= wr_valid_d;
         wr_adr_q     <= wr_adr_d;
         wr_sel_q     <= wr_sel_d;
         wr_dat_q     <= wr_dat_d;
         irq_q        <= 1'b0;
         firq_q       <= 1'b0;
      end
   end

   rdy_delay_counter #(
      .RDY_DELAY(RDY_DELAY)
   ) u_rdy_delay_counter (
      .clk       (i_clk),
      .rst       (i_rst),
      .system_rdy(o_system_rdy)
   );

   assign o_inst_ready = inst_ready_q;
   assign o_wb_ack     = (state_q == TermAck);
   assign o_wb_err     = (state_q == TermErr);
   assign o_wb_dat     = rd_dat_q;
   assign o_wr_valid   = wr_valid_q;
   assign o_wr_adr     = wr_adr_q;
   assign o_wr_sel     = wr_sel_q;
   assign o_wr_dat     = wr_dat_q;
   assign o_irq        = irq_q;
   assign o_firq       = firq_q;

endmodule

// File: tb/tb_wb128_inst_responder.sv
// Bench for wb128_inst_responder: directed plan items followed by random bus and
// instruction traffic, checked against a transaction-level reference model.
module tb_wb128_inst_responder;

   localparam logic [31:0] FILL = 32'hF0081003;
   localparam int unsigned RDY  = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  inst;
   logic         inst_valid;
   logic         inst_ready;
   logic [31:0]  wb_adr;
   logic [15:0]  wb_sel;
   logic         wb_we;
   logic [127:0] wb_dat_w;
   logic [127:0] wb_dat_r;
   logic         wb_cyc;
   logic         wb_stb;
   logic         wb_ack;
   logic         wb_err;
   logic         wr_valid;
   logic [31:0]  wr_adr;
   logic [15:0]  wr_sel;
   logic [127:0] wr_dat;
   logic         irq;
   logic         firq;
   logic         system_rdy;

   wb128_inst_responder #(
      .FILL_WORD(FILL),
      .RDY_DELAY(RDY)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_inst      (inst),
      .i_inst_valid(inst_valid),
      .o_inst_ready(inst_ready),
      .i_wb_adr    (wb_adr),
      .i_wb_sel    (wb_sel),
      .i_wb_we     (wb_we),
      .i_wb_dat    (wb_dat_w),
      .o_wb_dat    (wb_dat_r),
      .i_wb_cyc    (wb_cyc),
      .i_wb_stb    (wb_stb),
      .o_wb_ack    (wb_ack),
      .o_wb_err    (wb_err),
      .o_wr_valid  (wr_valid),
      .o_wr_adr    (wr_adr),
      .o_wr_sel    (wr_sel),
      .o_wr_dat    (wr_dat),
      .o_irq       (irq),
      .o_firq      (firq),
      .o_system_rdy(system_rdy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: what the bus should show after each edge.
   logic         m_ack, m_err, m_full, m_wr_valid;
   logic [31:0]  m_inst, m_wr_adr;
   logic [15:0]  m_wr_sel;
   logic [127:0] m_rd, m_wr_dat;
   int           m_edges;

   task automatic model_reset();
      m_ack      = 1'b0;
      m_err      = 1'b0;
      m_full     = 1'b0;
      m_inst     = 32'd0;
      m_rd       = {FILL, FILL, FILL, FILL};
      m_wr_valid = 1'b0;
      m_wr_adr   = 32'd0;
      m_wr_sel   = 16'd0;
      m_wr_dat   = 128'd0;
      m_edges    = 0;
   endtask

   task automatic model_edge();
      bit was_terminating, is_req, good, rd, taking;
      was_terminating = m_ack || m_err;
      is_req  = wb_cyc && wb_stb && !was_terminating;
      good    = is_req && (wb_sel != 16'd0);
      rd      = good && !wb_we;
      taking  = rd && m_full;
      m_ack   = good;
      m_err   = is_req && (wb_sel == 16'd0);
      m_wr_valid = good && wb_we;
      if (m_wr_valid) begin
         m_wr_adr = wb_adr;
         m_wr_sel = wb_sel;
         m_wr_dat = wb_dat_w;
      end
      if (rd) m_rd = {FILL, FILL, FILL, (m_full ? m_inst : FILL)};
      if (!m_full && inst_valid) begin
         m_full = 1'b1;
         m_inst = inst;
      end else if (taking) begin
         m_full = 1'b0;
      end
      if (m_edges < 100000) m_edges++;
   endtask

   task automatic check_outputs(input string ph);
      check_eq({ph, "_ack"},      128'(wb_ack),       128'(m_ack));
      check_eq({ph, "_err"},      128'(wb_err),       128'(m_err));
      check_eq({ph, "_rdat"},     wb_dat_r,           m_rd);
      check_eq({ph, "_ready"},    128'(inst_ready),   128'(!m_full));
      check_eq({ph, "_wrvalid"},  128'(wr_valid),     128'(m_wr_valid));
      check_eq({ph, "_wradr"},    128'(wr_adr),       128'(m_wr_adr));
      check_eq({ph, "_wrsel"},    128'(wr_sel),       128'(m_wr_sel));
      check_eq({ph, "_wrdat"},    wr_dat,             m_wr_dat);
      check_eq({ph, "_irq"},      128'({irq, firq}),  128'(0));
      check_eq({ph, "_sysrdy"},   128'(system_rdy),   128'(m_edges >= int'(RDY)));
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic step(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(ph);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_async");
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic bus_idle();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      wb_sel = 16'd0;
   endtask

   task automatic bus_req(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                          input logic [127:0] dat);
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = we;
      wb_adr   = adr;
      wb_sel   = sel;
      wb_dat_w = dat;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_rdy;
      int ack_pat;
      rst        = 1'b0;
      inst       = 32'd0;
      inst_valid = 1'b0;
      wb_adr     = 32'd0;
      wb_dat_w   = 128'd0;
      bus_idle();
      model_reset();
      @(negedge clk);
      do_reset();

      // system_rdy rises on the RDY-th edge after release
      first_rdy = 0;
      for (int e = 1; e <= 12; e++) begin
         step("boot");
         if (system_rdy && first_rdy == 0) first_rdy = e;
      end
      check_eq("rdy_edge", 128'(first_rdy), 128'(RDY));

      // Load then read the instruction
      inst = 32'hE3A01005;
      inst_valid = 1'b1;
      step("load");
      inst_valid = 1'b0;
      bus_req(1'b0, 32'h0, 16'hFFFF, 128'd0);
      step("read_full");
      check_eq("plan_read_dat", wb_dat_r, 128'hF0081003F0081003F0081003E3A01005);
      bus_idle();
      step("read_full_end");
      check_eq("plan_ready_back", 128'(inst_ready), 128'(1));

      // Read while empty
      bus_req(1'b0, 32'h4, 16'hFFFF, 128'd0);
      step("read_empty");
      check_eq("plan_empty_dat", wb_dat_r, 128'hF0081003F0081003F0081003F0081003);
      bus_idle();
      step("read_empty_end");

      // Write capture
      bus_req(1'b1, 32'h100, 16'h000F, 128'h1234);
      step("write");
      check_eq("plan_wr_fields", {wr_adr, wr_sel, wr_valid, wb_ack},
               {32'h100, 16'h000F, 1'b1, 1'b1});
      check_eq("plan_wr_dat", wr_dat, 128'h1234);
      bus_idle();
      step("write_end");

      // Zero selects: error, holding register untouched
      inst = 32'h12345678;
      inst_valid = 1'b1;
      step("load2");
      inst_valid = 1'b0;
      bus_req(1'b0, 32'h8, 16'h0000, 128'd0);
      step("err");
      check_eq("plan_err", {wb_err, wb_ack, inst_ready}, {1'b1, 1'b0, 1'b0});
      bus_idle();
      step("err_end");
      bus_req(1'b0, 32'h8, 16'hFFFF, 128'd0);
      step("drain");
      bus_idle();
      step("drain_end");

      // Held stb: ack alternates, then reset while an ack is pending
      ack_pat = 0;
      bus_req(1'b0, 32'hC, 16'hFFFF, 128'd0);
      for (int i = 0; i < 4; i++) begin
         step("held");
         ack_pat = (ack_pat << 1) | int'(wb_ack);
      end
      check_eq("plan_held_pattern", 128'(ack_pat), 128'(4'b1010));
      step("held_pend");
      bus_idle();
      do_reset();
      first_rdy = 0;
      for (int e = 1; e <= 12; e++) begin
         step("reboot");
         if (system_rdy && first_rdy == 0) first_rdy = e;
      end
      check_eq("rdy_restart", 128'(first_rdy), 128'(RDY));

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         inst       = $urandom;
         inst_valid = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) != 0) begin
            wb_cyc = 1'b1;
            wb_stb = ($urandom_range(0, 4) != 0);
         end else begin
            wb_cyc = ($urandom_range(0, 1) == 1);
            wb_stb = 1'b0;
         end
         wb_we    = ($urandom_range(0, 2) == 0);
         wb_sel   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         wb_adr   = $urandom;
         wb_dat_w = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            step("rand");
         end
      end
      bus_idle();
      step("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
